t06_multi_tick_gen: RTL and testbench

Multi-channel programmable tick generator and clock divider for the team 06 datapath. Each of NCH independent channels runs a WIDTH-bit terminal counter against its own limit, and emits a registered one-cycle tick plus a 50%-duty divided toggle. Each channel runs in periodic (free-running) or one-shot mode, with per-channel enable (pause) and restart. It replaces per-consumer single-channel dividers for display refresh, debounce and timeout timing.

---
 rtl/t06_multi_tick_gen_if.sv | 27 ++
 rtl/t06_multi_tick_gen.sv | 104 ++++++++++
 tb/tb_t06_multi_tick_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/t06_multi_tick_gen_if.sv
// Signal bundle for the multi-channel tick generator.
// Channel c occupies bit c of the per-channel vectors and slice [c*WIDTH +: WIDTH]
// of the limit and count buses.
interface t06_multi_tick_gen_if #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 19
);
    logic [NCH-1:0]       en_i;
    logic [NCH-1:0]       mode_i;
    logic [NCH-1:0]       start_i;
    logic [NCH*WIDTH-1:0] max_i;
    logic [NCH-1:0]       tick_o;
    logic [NCH-1:0]       toggle_o;
    logic [NCH-1:0]       busy_o;
    logic [NCH-1:0]       done_o;
    logic [NCH*WIDTH-1:0] count_o;

    modport master (
        output en_i, mode_i, start_i, max_i,
        input  tick_o, toggle_o, busy_o, done_o, count_o
    );

    modport slave (
        input  en_i, mode_i, start_i, max_i,
        output tick_o, toggle_o, busy_o, done_o, count_o
    );
endinterface

// File: rtl/t06_multi_tick_gen.sv
// Multi-channel programmable tick generator / clock divider.
// Each channel counts up to its own limit M and emits a registered one-cycle
// tick plus a divided toggle, in periodic or one-shot mode. Channels share
// nothing but the clock and reset.
module t06_multi_tick_gen #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    t06_multi_tick_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                     state_q [NCH];
    state_e                     state_d [NCH];
    logic [NCH-1:0][WIDTH-1:0]  count_q;
    logic [NCH-1:0][WIDTH-1:0]  count_d;
    logic [NCH-1:0][WIDTH-1:0]  limit;
    logic [NCH-1:0]             tick_q;
    logic [NCH-1:0]             tick_d;
    logic [NCH-1:0]             toggle_q;
    logic [NCH-1:0]             toggle_d;
    logic [NCH-1:0]             term;
    logic [NCH-1:0]             step;

    assign limit = bus.max_i;

    // Per-channel state, count, tick and toggle registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                state_q[c] <= IDLE;
            end
            count_q  <= '0;
            tick_q   <= '0;
            toggle_q <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                state_q[c] <= state_d[c];
            end
            count_q  <= count_d;
            tick_q   <= tick_d;
            toggle_q <= toggle_d;
        end
    end

    // Next-state logic: start wins over a count step, which wins over hold.
    // A periodic channel in IDLE with enable set steps exactly as RUN would.
    // term uses >= so a limit lowered below the count ends the period on the
    // next enabled edge instead of wrapping.
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
        end
        count_d  = count_q;
        tick_d   = '0;
        toggle_d = toggle_q;
        term     = '0;
        step     = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            term[c] = (count_q[c] >= limit[c]);
            step[c] = bus.en_i[c] &&
                      ((state_q[c] == RUN) || ((state_q[c] == IDLE) && !bus.mode_i[c]));
            if (bus.start_i[c]) begin
                count_d[c] = '0;
                state_d[c] = RUN;
            end else if (step[c]) begin
                state_d[c] = RUN;
                if (term[c]) begin
                    tick_d[c]   = 1'b1;
                    toggle_d[c] = ~toggle_q[c];
                    if (bus.mode_i[c]) begin
                        state_d[c] = DONE;
                    end else begin
                        count_d[c] = '0;
                    end
                end else begin
                    count_d[c] = count_q[c] + WIDTH'(1);
                end
            end
        end
    end

    // Status outputs are plain decodes of the state registers.
    always_comb begin
        bus.busy_o = '0;
        bus.done_o = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            bus.busy_o[c] = (state_q[c] == RUN);
            bus.done_o[c] = (state_q[c] == DONE);
        end
    end

    assign bus.tick_o   = tick_q;
    assign bus.toggle_o = toggle_q;
    assign bus.count_o  = count_q;

endmodule

// File: tb/tb_t06_multi_tick_gen.sv
// Directed self-checking bench for t06_multi_tick_gen.
module tb_t06_multi_tick_gen;

    localparam int unsigned NCH   = 4;
    localparam int unsigned WIDTH = 19;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    t06_multi_tick_gen_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

    t06_multi_tick_gen #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] cnt(input int c);
        return bus.count_o[c*WIDTH +: WIDTH];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"},   bus.tick_o,   '0);
        chk({tag, "_toggle"}, bus.toggle_o, '0);
        chk({tag, "_busy"},   bus.busy_o,   '0);
        chk({tag, "_done"},   bus.done_o,   '0);
        chk({tag, "_count"},  bus.count_o,  '0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.en_i    = '0;
        bus.mode_i  = '1;
        bus.start_i = '0;
        bus.max_i   = '0;
        clk_n(2);
        chk_all_zero("reset");

        // A: ch0 periodic M=3, ticks on cycles 4, 8, 12
        rst = 1'b0;
        bus.mode_i[0] = 1'b0;
        bus.max_i[0*WIDTH +: WIDTH] = 19'd3;
        bus.en_i[0] = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            clk_n(1);
            chk($sformatf("A_count_c%0d", cyc), cnt(0), 128'(cyc % 4));
            chk($sformatf("A_tick_c%0d", cyc), bus.tick_o[0], 128'(cyc % 4 == 0));
            chk($sformatf("A_toggle_c%0d", cyc), bus.toggle_o[0], 128'((cyc / 4) % 2));
        end
        chk("A_busy", bus.busy_o[0], 1'b1);
        chk("A_done", bus.done_o[0], 1'b0);

        // B: ch1 one-shot M=5, tick 6 edges after start, exactly once
        bus.max_i[1*WIDTH +: WIDTH] = 19'd5;
        bus.en_i[1]    = 1'b1;
        bus.start_i[1] = 1'b1;
        clk_n(1);
        bus.start_i[1] = 1'b0;
        chk("B_start_count", cnt(1), 0);
        chk("B_start_busy", bus.busy_o[1], 1'b1);
        for (int k = 1; k <= 5; k++) begin
            clk_n(1);
            chk($sformatf("B_count_%0d", k), cnt(1), 128'(k));
            chk($sformatf("B_notick_%0d", k), bus.tick_o[1], 1'b0);
        end
        clk_n(1);
        chk("B_tick", bus.tick_o[1], 1'b1);
        chk("B_done", bus.done_o[1], 1'b1);
        chk("B_busy_off", bus.busy_o[1], 1'b0);
        chk("B_toggle1", bus.toggle_o[1], 1'b1);
        clk_n(3);
        chk("B_hold_tick", bus.tick_o[1], 1'b0);
        chk("B_hold_count", cnt(1), 5);
        chk("B_hold_done", bus.done_o[1], 1'b1);
        bus.start_i[1] = 1'b1;
        clk_n(1);
        bus.start_i[1] = 1'b0;
        chk("B_restart_count", cnt(1), 0);
        chk("B_restart_done", bus.done_o[1], 1'b0);
        clk_n(5);
        chk("B2_notick", bus.tick_o[1], 1'b0);
        clk_n(1);
        chk("B2_tick", bus.tick_o[1], 1'b1);
        chk("B2_toggle", bus.toggle_o[1], 1'b0);

        // C: ch0 periodic M=9 with a 3-cycle pause at count 4
        rst = 1'b1;
        bus.en_i   = '0;
        bus.mode_i = '1;
        clk_n(1);
        chk_all_zero("C_reset");
        rst = 1'b0;
        bus.mode_i[0] = 1'b0;
        bus.max_i[0*WIDTH +: WIDTH] = 19'd9;
        bus.en_i[0] = 1'b1;
        clk_n(4);
        chk("C_count4", cnt(0), 4);
        bus.en_i[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clk_n(1);
            chk($sformatf("C_pause_count_%0d", k), cnt(0), 4);
            chk($sformatf("C_pause_tick_%0d", k), bus.tick_o[0], 1'b0);
        end
        chk("C_pause_busy", bus.busy_o[0], 1'b1);
        bus.en_i[0] = 1'b1;
        for (int k = 5; k <= 9; k++) begin
            clk_n(1);
            chk($sformatf("C_count_%0d", k), cnt(0), 128'(k));
            chk($sformatf("C_notick_%0d", k), bus.tick_o[0], 1'b0);
        end
        clk_n(1);
        chk("C_tick", bus.tick_o[0], 1'b1);
        chk("C_wrap", cnt(0), 0);

        // D: ch2 M lowered from 100 to 10 at count 50
        bus.mode_i[2] = 1'b0;
        bus.max_i[2*WIDTH +: WIDTH] = 19'd100;
        bus.en_i[2] = 1'b1;
        clk_n(50);
        chk("D_count50", cnt(2), 50);
        chk("D_notick", bus.tick_o[2], 1'b0);
        bus.max_i[2*WIDTH +: WIDTH] = 19'd10;
        clk_n(1);
        chk("D_tick", bus.tick_o[2], 1'b1);
        chk("D_count0", cnt(2), 0);
        clk_n(1);
        chk("D_count1", cnt(2), 1);
        chk("D_tick_off", bus.tick_o[2], 1'b0);

        // E: ch3 M=0 periodic, then start on a terminal edge
        bus.mode_i[3] = 1'b0;
        bus.max_i[3*WIDTH +: WIDTH] = 19'd0;
        bus.en_i[3] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            clk_n(1);
            chk($sformatf("E_tick_%0d", k), bus.tick_o[3], 1'b1);
            chk($sformatf("E_toggle_%0d", k), bus.toggle_o[3], 128'(k % 2));
            chk($sformatf("E_count_%0d", k), cnt(3), 0);
        end
        bus.start_i[3] = 1'b1;
        clk_n(1);
        bus.start_i[3] = 1'b0;
        chk("E_start_tick", bus.tick_o[3], 1'b0);
        chk("E_start_toggle", bus.toggle_o[3], 1'b0);
        chk("E_start_count", cnt(3), 0);
        chk("E_start_busy", bus.busy_o[3], 1'b1);
        clk_n(1);
        chk("E_after_tick", bus.tick_o[3], 1'b1);
        chk("E_after_toggle", bus.toggle_o[3], 1'b1);

        // F: reset mid-run on all channels; one-shot ch1 stays idle afterwards
        bus.mode_i[1]  = 1'b1;
        bus.start_i[1] = 1'b1;
        clk_n(1);
        bus.start_i[1] = 1'b0;
        clk_n(2);
        chk("F_pre_busy", bus.busy_o, 4'b1111);
        rst = 1'b1;
        clk_n(1);
        chk_all_zero("F_reset");
        rst = 1'b0;
        bus.en_i = '1;
        clk_n(3);
        chk("F_os_busy", bus.busy_o[1], 1'b0);
        chk("F_os_done", bus.done_o[1], 1'b0);
        chk("F_os_count", cnt(1), 0);
        chk("F_per_count", cnt(0), 3);
        chk("F_per_busy", bus.busy_o[0], 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
